// File: rtl/riscv_div_pkg.sv
// Shared definitions for the iterative divider: operator and FSM state encodings.
package riscv_div_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'b00,
        DIV_DIVU = 2'b01,
        DIV_REM  = 2'b10,
        DIV_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIVIDE = 2'b01,
        FINISH = 2'b10
    } div_state_e;

endpackage

// File: rtl/riscv_div_if.sv
// EX-stage handshake between the pipeline (master) and the divide unit (slave).
interface riscv_div_if;
    import riscv_div_pkg::*;

    logic                enable_i;
    div_op_e             operator_i;
    logic [DATA_W-1:0]   op_a_i;
    logic [DATA_W-1:0]   op_b_i;
    logic [DATA_W-1:0]   result_o;
    logic                multicycle_o;
    logic                ready_o;
    logic                ex_ready_i;

    modport master (
        output enable_i, operator_i, op_a_i, op_b_i, ex_ready_i,
        input  result_o, multicycle_o, ready_o
    );

    modport slave (
        input  enable_i, operator_i, op_a_i, op_b_i, ex_ready_i,
        output result_o, multicycle_o, ready_o
    );

endinterface

// File: rtl/riscv_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Operands are reduced to magnitudes at capture; signs are restored in FINISH.
module riscv_div
    import riscv_div_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    riscv_div_if.slave bus
);

    div_state_e         state_q, state_d;
    div_op_e            op_q;
    logic [4:0]         cnt_q;
    logic [DATA_W:0]    rem_q;
    logic [DATA_W-1:0]  quo_q;
    logic [DATA_W-1:0]  div_q;
    logic               quo_neg_q;
    logic               rem_neg_q;

    logic               op_signed;
    logic [DATA_W-1:0]  abs_a;
    logic [DATA_W-1:0]  abs_b;
    logic               b_zero;
    logic               sgn_ovf;
    logic               early;
    logic               start;
    logic [DATA_W:0]    trial;
    logic [DATA_W-1:0]  quo_fix;
    logic [DATA_W-1:0]  rem_fix;
    logic               is_rem;
    logic               rem_msb_unused;

    assign op_signed = (bus.operator_i == DIV_DIV) || (bus.operator_i == DIV_REM);
    assign abs_a     = (op_signed && bus.op_a_i[DATA_W-1]) ? -bus.op_a_i : bus.op_a_i;
    assign abs_b     = (op_signed && bus.op_b_i[DATA_W-1]) ? -bus.op_b_i : bus.op_b_i;
    assign b_zero    = (bus.op_b_i == '0);
    assign sgn_ovf   = op_signed && (bus.op_a_i == 32'h8000_0000) && (bus.op_b_i == 32'hFFFF_FFFF);
    assign early     = EARLY_EXIT && (b_zero || sgn_ovf);
    assign start     = (state_q == IDLE) && bus.enable_i;

    // Trial subtraction of the divisor from the shifted partial remainder; bit 32 is the borrow.
    assign trial = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]} - {1'b0, div_q};

    // A completed step always leaves rem < div, so the remainder MSB never carries information out.
    assign rem_msb_unused = rem_q[DATA_W];

    assign quo_fix = quo_neg_q ? -quo_q : quo_q;
    assign rem_fix = rem_neg_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
    assign is_rem  = (op_q == DIV_REM) || (op_q == DIV_REMU);

    // Operand capture at start, then one restoring shift-subtract step per DIVIDE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= DIV_DIV;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (start) begin
            op_q      <= bus.operator_i;
            cnt_q     <= 5'd31;
            div_q     <= abs_b;
            // A zero divisor must yield all-ones regardless of the dividend sign.
            quo_neg_q <= op_signed && (bus.op_a_i[DATA_W-1] ^ bus.op_b_i[DATA_W-1]) && !b_zero;
            rem_neg_q <= op_signed && bus.op_a_i[DATA_W-1];
            // Early-exit divide-by-zero preloads what the loop would have produced;
            // early-exit overflow already holds the right values (|a| / 1, remainder 0).
            if (early && b_zero) begin
                quo_q <= '1;
                rem_q <= {1'b0, abs_a};
            end else begin
                quo_q <= abs_a;
                rem_q <= '0;
            end
        end else if (state_q == DIVIDE) begin
            cnt_q <= cnt_q - 5'd1;
            if (!trial[DATA_W]) begin
                rem_q <= trial;
                quo_q <= {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_q <= {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
                quo_q <= {quo_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: accept in IDLE, iterate 32 steps, hold the result until EX consumes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable_i) state_d = early ? FINISH : DIVIDE;
            DIVIDE:  if (cnt_q == 5'd0) state_d = FINISH;
            FINISH:  if (bus.ex_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs and sign-corrected result, driven only in FINISH.
    always_comb begin
        bus.ready_o      = 1'b0;
        bus.multicycle_o = 1'b0;
        bus.result_o     = '0;
        case (state_q)
            IDLE:   bus.ready_o = !bus.enable_i;
            DIVIDE: bus.multicycle_o = 1'b1;
            FINISH: begin
                bus.ready_o  = 1'b1;
                bus.result_o = is_rem ? rem_fix : quo_fix;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_div.sv
// Self-checking bench: one divider with early exit and one without, fed the same operations.
module tb_riscv_div;
    import riscv_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        exr;
    div_op_e     opr;
    logic [31:0] a;
    logic [31:0] b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    riscv_div_if if1();
    riscv_div_if if0();

    assign if1.enable_i   = en;
    assign if1.operator_i = opr;
    assign if1.op_a_i     = a;
    assign if1.op_b_i     = b;
    assign if1.ex_ready_i = exr;
    assign if0.enable_i   = en;
    assign if0.operator_i = opr;
    assign if0.op_a_i     = a;
    assign if0.op_b_i     = b;
    assign if0.ex_ready_i = exr;

    riscv_div #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    riscv_div #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    function automatic logic [31:0] ref_div(div_op_e op, logic [31:0] x, logic [31:0] y);
        logic        sgn;
        logic        isrem;
        logic [31:0] qt;
        logic [31:0] rm;
        sgn   = (op == DIV_DIV) || (op == DIV_REM);
        isrem = (op == DIV_REM) || (op == DIV_REMU);
        if (y == 32'd0) begin
            qt = 32'hFFFF_FFFF;
            rm = x;
        end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            qt = 32'h8000_0000;
            rm = 32'd0;
        end else if (sgn) begin
            qt = $signed(x) / $signed(y);
            rm = $signed(x) % $signed(y);
        end else begin
            qt = x / y;
            rm = x % y;
        end
        return isrem ? rm : qt;
    endfunction

    function automatic bit is_special(div_op_e op, logic [31:0] x, logic [31:0] y);
        return (y == 32'd0) ||
               (((op == DIV_DIV) || (op == DIV_REM)) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // Called just after a rising edge: present the op for one cycle and queue its expectation.
    task automatic start_op(string name, div_op_e op, logic [31:0] x, logic [31:0] y);
        exp_t e;
        e.res = ref_div(op, x, y);
        e.lat = is_special(op, x, y) ? 1 : 33;
        q1.push_back(e);
        e.lat = 33;
        q0.push_back(e);
        en  = 1'b1;
        opr = op;
        a   = x;
        b   = y;
        @(negedge clk);
        n_vec++;
        if (if1.ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s start_ready ee1: got %b want 0", name, if1.ready_o);
        end
        n_vec++;
        if (if0.ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s start_ready ee0: got %b want 0", name, if0.ready_o);
        end
        @(posedge clk);
        #1;
        en  = 1'b0;
        opr = div_op_e'(2'($urandom));
        a   = $urandom;
        b   = $urandom;
    endtask

    // Watch both units after capture; each result must appear at its expected cycle.
    task automatic wait_results(string name);
        bit   s1 = 1'b0;
        bit   s0 = 1'b0;
        int   mc_bad1 = 0;
        int   mc_bad0 = 0;
        exp_t e;
        for (int k = 1; k <= 40 && !(s1 && s0); k++) begin
            @(negedge clk);
            if (!s1) begin
                if (if1.ready_o === 1'b1) begin
                    s1 = 1'b1;
                    e  = q1.pop_front();
                    n_vec++;
                    if (k != e.lat || if1.result_o !== e.res || if1.multicycle_o !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s ee1: result %h lat %0d mc %b, want result %h lat %0d mc 0",
                                 name, if1.result_o, k, if1.multicycle_o, e.res, e.lat);
                    end
                end else if (if1.multicycle_o !== 1'b1) begin
                    mc_bad1++;
                end
            end
            if (!s0) begin
                if (if0.ready_o === 1'b1) begin
                    s0 = 1'b1;
                    e  = q0.pop_front();
                    n_vec++;
                    if (k != e.lat || if0.result_o !== e.res || if0.multicycle_o !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s ee0: result %h lat %0d mc %b, want result %h lat %0d mc 0",
                                 name, if0.result_o, k, if0.multicycle_o, e.res, e.lat);
                    end
                end else if (if0.multicycle_o !== 1'b1) begin
                    mc_bad0++;
                end
            end
        end
        n_vec++;
        if (!s1 || mc_bad1 != 0) begin
            n_err++;
            $display("FAIL %s busy ee1: done %b, cycles without multicycle %0d, want done 1 and 0", name, s1, mc_bad1);
            if (!s1 && q1.size() > 0) void'(q1.pop_front());
        end
        n_vec++;
        if (!s0 || mc_bad0 != 0) begin
            n_err++;
            $display("FAIL %s busy ee0: done %b, cycles without multicycle %0d, want done 1 and 0", name, s0, mc_bad0);
            if (!s0 && q0.size() > 0) void'(q0.pop_front());
        end
    endtask

    task automatic run_op(string name, div_op_e op, logic [31:0] x, logic [31:0] y);
        start_op(name, op, x, y);
        wait_results(name);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(string name);
        n_vec++;
        if (if1.ready_o !== 1'b1 || if1.multicycle_o !== 1'b0 || if1.result_o !== 32'd0) begin
            n_err++;
            $display("FAIL %s ee1: ready %b mc %b result %h, want 1 0 00000000",
                     name, if1.ready_o, if1.multicycle_o, if1.result_o);
        end
        n_vec++;
        if (if0.ready_o !== 1'b1 || if0.multicycle_o !== 1'b0 || if0.result_o !== 32'd0) begin
            n_err++;
            $display("FAIL %s ee0: ready %b mc %b result %h, want 1 0 00000000",
                     name, if0.ready_o, if0.multicycle_o, if0.result_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        exr = 1'b1;
        opr = DIV_DIV;
        a   = 32'd0;
        b   = 32'd0;
        #2;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        run_op("divu_100_7", DIV_DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", DIV_REMU, 32'd100, 32'd7);
    endtask

    task automatic test_signed();
        run_op("div_m7_2",  DIV_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2",  DIV_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2",  DIV_DIV, 32'd7, 32'hFFFF_FFFE);
        run_op("rem_m9_m4", DIV_REM, 32'hFFFF_FFF7, 32'hFFFF_FFFC);
    endtask

    task automatic test_div_zero();
        run_op("div_by0",     DIV_DIV,  32'h1234_5678, 32'd0);
        run_op("remu_by0",    DIV_REMU, 32'h1234_5678, 32'd0);
        run_op("div_neg_by0", DIV_DIV,  32'hFFFF_FFF9, 32'd0);
        run_op("rem_neg_by0", DIV_REM,  32'hFFFF_FFF9, 32'd0);
        run_op("divu_by0",    DIV_DIVU, 32'h8000_0001, 32'd0);
    endtask

    task automatic test_overflow();
        run_op("div_ovf",  DIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",  DIV_REM,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_ovf", DIV_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_hold();
        exr = 1'b0;
        start_op("hold_divu", DIV_DIVU, 32'd1000, 32'd10);
        wait_results("hold_divu");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (if1.ready_o !== 1'b1 || if1.result_o !== 32'd100) begin
                n_err++;
                $display("FAIL hold ee1 cycle %0d: ready %b result %h, want 1 00000064", i, if1.ready_o, if1.result_o);
            end
            n_vec++;
            if (if0.ready_o !== 1'b1 || if0.result_o !== 32'd100) begin
                n_err++;
                $display("FAIL hold ee0 cycle %0d: ready %b result %h, want 1 00000064", i, if0.ready_o, if0.result_o);
            end
        end
        exr = 1'b1;
        @(posedge clk);
        #1;
        check_idle("release_to_idle");
        run_op("back_to_back", DIV_DIVU, 32'hFFFF_FFFF, 32'h10);
    endtask

    task automatic test_reset_mid();
        en  = 1'b1;
        opr = DIV_DIVU;
        a   = 32'd100;
        b   = 32'd7;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_vec++;
        if (if1.multicycle_o !== 1'b1 || if0.multicycle_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: mc ee1 %b ee0 %b, want 1 1", if1.multicycle_o, if0.multicycle_o);
        end
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("divu_9_3", DIV_DIVU, 32'd9, 32'd3);
    endtask

    task automatic test_random();
        div_op_e     op;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 8; i++) begin
            op = div_op_e'(2'($urandom_range(0, 3)));
            x  = $urandom;
            y  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 3) y = 32'hFFFF_FFFF;
            run_op("random", op, x, y);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

endmodule
